// File: rtl/wb_target_mem.sv
// wb_target_mem: Wishbone classic target memory with byte-lane writes,
// a fixed number of wait states, abort on t_cyc drop and error on out-of-range.
module wb_target_mem #(
    parameter int unsigned ADR_WIDTH   = 32,
    parameter int unsigned DAT_WIDTH   = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADR_WIDTH-1:0]   t_adr,
    input  logic [DAT_WIDTH-1:0]   t_dat_w,
    output logic [DAT_WIDTH-1:0]   t_dat_r,
    input  logic                   t_cyc,
    input  logic                   t_stb,
    input  logic                   t_we,
    input  logic [DAT_WIDTH/8-1:0] t_sel,
    output logic                   t_ack,
    output logic                   t_err
);
    localparam int unsigned SW = DAT_WIDTH / 8;
    localparam int unsigned LB = $clog2(SW);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t               state, state_next;
    logic [7:0]           cnt;
    logic [ADR_WIDTH-1:0] adr_q;
    logic [DAT_WIDTH-1:0] dat_q;
    logic [SW-1:0]        sel_q;
    logic                 we_q;
    logic                 access;
    logic                 in_range;
    logic [AW-1:0]        idx;
    logic [DAT_WIDTH-1:0] bmask;
    logic [DAT_WIDTH-1:0] mem [DEPTH];

    assign in_range = (adr_q >> (LB + AW)) == '0;
    assign idx      = AW'(adr_q >> LB);

    for (genvar g = 0; g < SW; g++) begin : g_lane
        assign bmask[8*g +: 8] = {8{sel_q[g]}};
    end

    always_comb begin
        state_next = state;
        access     = 1'b0;
        case (state)
            ST_IDLE: if (t_cyc && t_stb) state_next = ST_WAIT;
            ST_WAIT: begin
                if (!t_cyc) begin
                    state_next = ST_IDLE;
                end else if (cnt == '0) begin
                    access     = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Request is frozen at acceptance; later bus changes are ignored until IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt   <= '0;
            adr_q <= '0;
            dat_q <= '0;
            sel_q <= '0;
            we_q  <= 1'b0;
        end else if (state == ST_IDLE && t_cyc && t_stb) begin
            cnt   <= 8'(WAIT_STATES);
            adr_q <= t_adr;
            dat_q <= t_dat_w;
            sel_q <= t_sel;
            we_q  <= t_we;
        end else if (state == ST_WAIT && t_cyc && cnt != '0) begin
            cnt <= cnt - 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            t_ack   <= 1'b0;
            t_err   <= 1'b0;
            t_dat_r <= '0;
        end else begin
            t_ack <= access && in_range;
            t_err <= access && !in_range;
            if (access) begin
                if (!in_range)  t_dat_r <= '0;
                else if (!we_q) t_dat_r <= mem[idx];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && access && in_range && we_q)
            mem[idx] <= (mem[idx] & ~bmask) | (dat_q & bmask);
    end
endmodule

// File: tb/tb_wb_target_mem.sv
// Bench for wb_target_mem: four instances (0/3/4/5 wait states), scoreboard queue
// of expected responses, reference memory model per instance.
module tb_wb_target_mem;
    logic        clk = 1'b0;
    logic        rst [4];
    logic        cyc [4];
    logic        stb [4];
    logic        we  [4];
    logic [31:0] adr [4];
    logic [31:0] dw  [4];
    logic [31:0] dr  [4];
    logic [3:0]  sel [4];
    logic        ack [4];
    logic        err [4];

    int unsigned ws_tab [4] = '{0, 3, 4, 5};
    logic [31:0] model [4][1024];

    typedef struct {
        int          k;
        bit          exp_err;
        bit          chk_dat;
        logic [31:0] dat;
        int          lat;
    } exp_t;
    exp_t sbq [$];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        wb_target_mem #(
            .ADR_WIDTH  (32),
            .DAT_WIDTH  (32),
            .DEPTH      (1024),
            .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 3 : (g == 2) ? 4 : 5)
        ) dut (
            .clock  (clk),
            .reset  (rst[g]),
            .t_adr  (adr[g]),
            .t_dat_w(dw[g]),
            .t_dat_r(dr[g]),
            .t_cyc  (cyc[g]),
            .t_stb  (stb[g]),
            .t_we   (we[g]),
            .t_sel  (sel[g]),
            .t_ack  (ack[g]),
            .t_err  (err[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int k, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        exp_t       e;
        int         n;
        bit         done;
        logic [9:0] ix;
        e.k   = k;
        e.lat = int'(ws_tab[k]) + 1;
        ix    = a[11:2];
        if (a >= 32'h1000) begin
            e.exp_err = 1'b1;
            e.chk_dat = 1'b1;
            e.dat     = '0;
        end else begin
            e.exp_err = 1'b0;
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (s[i]) model[k][ix][8*i +: 8] = d[8*i +: 8];
                e.chk_dat = 1'b0;
                e.dat     = '0;
            end else begin
                e.chk_dat = 1'b1;
                e.dat     = model[k][ix];
            end
        end
        sbq.push_back(e);

        adr[k] = a; dw[k] = d; sel[k] = s; we[k] = w;
        cyc[k] = 1'b1; stb[k] = 1'b1;
        tick();
        n = 0;
        done = 1'b0;
        while (!done && n < 30) begin
            tick();
            n++;
            if (ack[k] || err[k]) done = 1'b1;
        end
        cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;

        e = sbq.pop_front();
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL timeout inst%0d adr=%h: no response in %0d cycles", k, a, n);
        end else begin
            if (n != e.lat) begin
                miscompares++;
                $display("FAIL latency inst%0d adr=%h: got %0d required %0d", k, a, n, e.lat);
            end
            vectors++;
            if ({ack[k], err[k]} !== {~e.exp_err, e.exp_err}) begin
                miscompares++;
                $display("FAIL term inst%0d adr=%h: ack/err got %b%b required %b%b",
                         k, a, ack[k], err[k], ~e.exp_err, e.exp_err);
            end
            if (e.chk_dat) begin
                vectors++;
                if (dr[k] !== e.dat) begin
                    miscompares++;
                    $display("FAIL rdata inst%0d adr=%h: got %h required %h", k, a, dr[k], e.dat);
                end
            end
        end
        tick();
        vectors++;
        if (ack[k] !== 1'b0 || err[k] !== 1'b0) begin
            miscompares++;
            $display("FAIL pulse inst%0d adr=%h: ack/err got %b%b required 00", k, a, ack[k], err[k]);
        end
    endtask

    task automatic expect_quiet(input int k, input int cycles, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (ack[k] !== 1'b0 || err[k] !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL %s inst%0d: response seen, required none", tag, k);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) rst[k] = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < 4; k++) rst[k] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (ack[k] !== 1'b0 || err[k] !== 1'b0 || dr[k] !== 32'h0) begin
                miscompares++;
                $display("FAIL reset inst%0d: ack=%b err=%b dat=%h required 0 0 0", k, ack[k], err[k], dr[k]);
            end
        end
    endtask

    task automatic test_write_read();
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF);
        vectors++;
        if (dr[0] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL write_read: got %h required deadbeef", dr[0]);
        end
    endtask

    task automatic test_byte_lanes();
        xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF);
        xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
        xfer(0, 1'b0, 32'h20, 32'h0, 4'h0);
        vectors++;
        if (dr[0] !== 32'h11BB33DD) begin
            miscompares++;
            $display("FAIL byte_lanes: got %h required 11bb33dd", dr[0]);
        end
    endtask

    task automatic test_wait_states();
        xfer(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
        xfer(1, 1'b0, 32'h40, 32'h0, 4'hF);
        xfer(1, 1'b0, 32'h43, 32'h0, 4'h1);
    endtask

    task automatic test_out_of_range();
        xfer(0, 1'b1, 32'h0, 32'h01234567, 4'hF);
        xfer(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
        xfer(0, 1'b0, 32'h1000, 32'h0, 4'hF);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'hF);
        vectors++;
        if (dr[0] !== 32'h01234567) begin
            miscompares++;
            $display("FAIL oor_word0: got %h required 01234567", dr[0]);
        end
    endtask

    task automatic test_abort();
        int drop_at [2] = '{2, 4};
        xfer(2, 1'b1, 32'h8, 32'h55AA55AA, 4'hF);
        for (int j = 0; j < 2; j++) begin
            adr[2] = 32'h8; dw[2] = 32'h0; sel[2] = 4'hF; we[2] = 1'b1;
            cyc[2] = 1'b1; stb[2] = 1'b1;
            tick();
            repeat (drop_at[j]) tick();
            cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
            expect_quiet(2, 8, "abort");
            xfer(2, 1'b0, 32'h8, 32'h0, 4'hF);
        end
    endtask

    task automatic test_reset_mid_wait();
        xfer(3, 1'b1, 32'h30, 32'h13579BDF, 4'hF);
        xfer(3, 1'b0, 32'h30, 32'h0, 4'hF);
        adr[3] = 32'h30; dw[3] = 32'h0; sel[3] = 4'hF; we[3] = 1'b1;
        cyc[3] = 1'b1; stb[3] = 1'b1;
        tick();
        repeat (2) tick();
        rst[3] = 1'b1;
        cyc[3] = 1'b0; stb[3] = 1'b0; we[3] = 1'b0;
        tick();
        vectors++;
        if (ack[3] !== 1'b0 || err[3] !== 1'b0 || dr[3] !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_wait inst3: ack=%b err=%b dat=%h required 0 0 0", ack[3], err[3], dr[3]);
        end
        rst[3] = 1'b0;
        expect_quiet(3, 8, "reset_wait");
        xfer(3, 1'b0, 32'h30, 32'h0, 4'hF);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            rst[k] = 1'b1; cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
            adr[k] = '0; dw[k] = '0; sel[k] = '0;
        end
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_wait_states();
        test_out_of_range();
        test_abort();
        test_reset_mid_wait();
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard: %0d entries left, required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
